ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arb_rr.sv | 20 ++
 rtl/ram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Purpose: shared owner encoding, round-robin pointer encoding and default widths for the RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_BLT  = 2'd3
    } owner_t;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 16;

    // rr_ptr value naming the port that wins a CPU/BLT tie
    localparam logic RR_CPU = 1'b0;
    localparam logic RR_BLT = 1'b1;

endpackage

// File: rtl/ram_arb_rr.sv
// Purpose: two-way CPU/BLT round-robin pick; a lone requester always wins, a tie goes to rr_ptr.
// Latency: purely combinational.
// Backpressure: none; a port not picked simply keeps its request up.
// Ports: cpu_req/blt_req requests, rr_ptr preferred port, pick_cpu/pick_blt one-hot-or-zero result.
module ram_arb_rr
    import ram_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic blt_req,
    input  logic rr_ptr,
    output logic pick_cpu,
    output logic pick_blt
);

    always_comb begin
        pick_cpu = cpu_req && (!blt_req || (rr_ptr == RR_CPU));
        pick_blt = blt_req && (!cpu_req || (rr_ptr == RR_BLT));
    end

endmodule

// File: rtl/ram_arbiter.sv
// Purpose: arbitrates loader/CPU/blitter onto one synchronous RAM with priority, round-robin and burst locking.
// Latency: grant combinational in cycle N, RAM command in N+1, read data + rvalid in N+2.
// Backpressure: a requester holds its request stable until its gnt; ungranted ports simply wait.
// Ports: clk/res; ld_*, cpu_*, blt_* request ports with *_gnt and *_rvalid; shared rdata;
//        ram_en/ram_wr/ram_addr/ram_in command to the RAM, ram_out read data from it.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              res,
    input  logic              ld_req,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    input  logic              blt_req,
    input  logic              blt_wr,
    input  logic              blt_lock,
    input  logic [ADDR_W-1:0] blt_addr,
    input  logic [DATA_W-1:0] blt_wdata,
    output logic              blt_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              ld_rvalid,
    output logic              cpu_rvalid,
    output logic              blt_rvalid,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    localparam int              CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    // A one-cycle burst limit means a lock can never outlive its own grant
    localparam bit              CAN_LOCK  = (MAX_BURST > 1);

    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              rr_cpu, rr_blt;
    logic              own_lock;
    logic              any_gnt;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        rd_pend_q;   // {ld, cpu, blt} read accepted last cycle
    logic [2:0]        rvalid_q;

    ram_arb_rr u_rr (
        .cpu_req  (cpu_req),
        .blt_req  (blt_req),
        .rr_ptr   (rr_q),
        .pick_cpu (rr_cpu),
        .pick_blt (rr_blt)
    );

    // Grant: only the owner may be served while a lock is held; otherwise loader first, then round-robin
    always_comb begin
        ld_gnt  = 1'b0;
        cpu_gnt = 1'b0;
        blt_gnt = 1'b0;
        if (!res) begin
            case (owner_q)
                OWN_CPU: cpu_gnt = cpu_req;
                OWN_BLT: blt_gnt = blt_req;
                default: begin
                    if (ld_req) begin
                        ld_gnt = 1'b1;
                    end else begin
                        cpu_gnt = rr_cpu;
                        blt_gnt = rr_blt;
                    end
                end
            endcase
        end
    end

    // Owner / burst counter / rr pointer next state
    always_comb begin
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        own_lock = 1'b0;
        if (cpu_gnt) rr_d = RR_BLT;
        if (blt_gnt) rr_d = RR_CPU;
        case (owner_q)
            OWN_CPU, OWN_BLT: begin
                own_lock = (owner_q == OWN_CPU) ? cpu_lock : blt_lock;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_d == BURST_MAX) begin
                    // forced release hands the tie-break to the peer that has been waiting
                    owner_d = OWN_NONE;
                    cnt_d   = '0;
                    rr_d    = (owner_q == OWN_CPU) ? RR_BLT : RR_CPU;
                end else if (!own_lock) begin
                    owner_d = OWN_NONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                owner_d = OWN_NONE;
                cnt_d   = '0;
                if (CAN_LOCK && cpu_gnt && cpu_lock) begin
                    owner_d = OWN_CPU;
                    cnt_d   = CNT_W'(1);
                end
                if (CAN_LOCK && blt_gnt && blt_lock) begin
                    owner_d = OWN_BLT;
                    cnt_d   = CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
            rr_q    <= RR_CPU;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Command mux for the granted port
    always_comb begin
        any_gnt   = ld_gnt || cpu_gnt || blt_gnt;
        sel_wr    = ld_wr;
        sel_addr  = ld_addr;
        sel_wdata = ld_wdata;
        if (cpu_gnt) begin
            sel_wr    = cpu_wr;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end
        if (blt_gnt) begin
            sel_wr    = blt_wr;
            sel_addr  = blt_addr;
            sel_wdata = blt_wdata;
        end
    end

    // Reset wipes the read pipeline so a read accepted just before reset never reports rvalid
    always_ff @(posedge clk) begin
        if (res) begin
            ram_en    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_in    <= '0;
            rd_pend_q <= '0;
            rvalid_q  <= '0;
        end else begin
            ram_en    <= any_gnt;
            ram_wr    <= any_gnt && sel_wr;
            if (any_gnt) begin
                ram_addr <= sel_addr;
                ram_in   <= sel_wdata;
            end
            rd_pend_q <= {ld_gnt && !ld_wr, cpu_gnt && !cpu_wr, blt_gnt && !blt_wr};
            rvalid_q  <= rd_pend_q;
        end
    end

    // RAM output arrives one cycle after ram_en, which lines up with rvalid_q
    assign rdata      = (|rvalid_q) ? ram_out : '0;
    assign ld_rvalid  = rvalid_q[2];
    assign cpu_rvalid = rvalid_q[1];
    assign blt_rvalid = rvalid_q[0];

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          res;
    logic          ld_req, ld_wr, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          cpu_req, cpu_wr, cpu_lock, cpu_gnt;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          blt_req, blt_wr, blt_lock, blt_gnt;
    logic [AW-1:0] blt_addr;
    logic [DW-1:0] blt_wdata;
    logic [DW-1:0] rdata;
    logic          ld_rvalid, cpu_rvalid, blt_rvalid;
    logic          ram_en, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) dut (
        .clk(clk), .res(res),
        .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .blt_req(blt_req), .blt_wr(blt_wr), .blt_lock(blt_lock), .blt_addr(blt_addr),
        .blt_wdata(blt_wdata), .blt_gnt(blt_gnt),
        .rdata(rdata), .ld_rvalid(ld_rvalid), .cpu_rvalid(cpu_rvalid), .blt_rvalid(blt_rvalid),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_in(ram_in), .ram_out(ram_out)
    );

    // Synchronous RAM with one-cycle read latency
    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_in;
            else        ram_out <= mem[ram_addr];
        end
    end

    typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } ram_exp_t;
    typedef struct packed { logic [1:0] port; logic [DW-1:0] data; } rd_exp_t;

    int       exp_gnt[$];
    ram_exp_t exp_ram[$];
    rd_exp_t  exp_rd[$];
    int       gnt_time[$];
    int       rd_time[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int port_of(input logic [2:0] v);
        case (v)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 0;
        endcase
    endfunction

    // port: 1=LD 2=CPU 3=BLT; for reads data is the expected read data
    task automatic expect_acc(input int port, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic has_rd);
        ram_exp_t e;
        rd_exp_t  r;
        e.wr = wr; e.addr = addr; e.data = data;
        exp_gnt.push_back(port);
        exp_ram.push_back(e);
        if (!wr && has_rd) begin
            r.port = 2'(port); r.data = data;
            exp_rd.push_back(r);
        end
    endtask

    // Monitor: compares every grant, RAM command and read return against the expectation queues
    always @(negedge clk) begin
        logic [2:0] gv, rv;
        ram_exp_t   e;
        rd_exp_t    r;
        gv = {ld_gnt, cpu_gnt, blt_gnt};
        rv = {ld_rvalid, cpu_rvalid, blt_rvalid};
        if (gv != 3'b000) begin
            chk("gnt_onehot", $countones(gv), 1);
            if (exp_gnt.size() == 0) chk("unexpected_gnt", 32'(gv), 0);
            else chk("gnt_port", port_of(gv), exp_gnt.pop_front());
            gnt_time.push_back(cyc);
        end
        if (ram_en) begin
            if (exp_ram.size() == 0) begin
                chk("unexpected_ram_en", {ram_wr, ram_addr}, 0);
            end else begin
                e = exp_ram.pop_front();
                chk("ram_wr", 32'(ram_wr), 32'(e.wr));
                chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                if (e.wr) chk("ram_in", 32'(ram_in), 32'(e.data));
            end
            if (gnt_time.size() == 0) chk("ram_en_no_gnt", 1, 0);
            else chk("ram_en_latency", cyc, gnt_time.pop_front() + 1);
            if (!ram_wr) rd_time.push_back(cyc);
        end
        if (rv != 3'b000) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_rvalid", 32'(rv), 0);
            end else begin
                r = exp_rd.pop_front();
                chk("rvalid_port", port_of(rv), 32'(r.port));
                chk("rdata", 32'(rdata), 32'(r.data));
            end
            if (rd_time.size() == 0) chk("rvalid_no_read", 1, 0);
            else chk("rvalid_latency", cyc, rd_time.pop_front() + 1);
        end
        if (res) begin
            gnt_time.delete();
            rd_time.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int got = 0;
        int budget = 100;
        while (got < n && budget > 0) begin
            @(negedge clk);
            if (ld_gnt || cpu_gnt || blt_gnt) got++;
            budget--;
        end
        chk("grant_wait", got, n);
    endtask

    task automatic reset_checks();
        chk("rst_gnt", {ld_gnt, cpu_gnt, blt_gnt}, 0);
        chk("rst_ram_en", {ram_en, ram_wr}, 0);
        chk("rst_rvalid", {ld_rvalid, cpu_rvalid, blt_rvalid}, 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_in", 32'(ram_in), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h180] = 8'h6A;
        mem[12'h010] = 8'h11;
        mem[12'h020] = 8'h22;
        mem[12'h040] = 8'hA0;
        mem[12'h041] = 8'hA1;
        mem[12'h042] = 8'hA2;
        mem[12'h043] = 8'hA3;
        res = 1'b1;
        ld_req = 1'b1; ld_wr = 1'b0; ld_addr = '0; ld_wdata = '0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        blt_req = 1'b1; blt_wr = 1'b0; blt_lock = 1'b0; blt_addr = '0; blt_wdata = '0;

        // Reset with all requests up: nothing granted, all outputs cleared
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks();
        step();
        res = 1'b0; ld_req = 1'b0; cpu_req = 1'b0; blt_req = 1'b0;
        repeat (2) step();

        // Uncontended CPU read of 0x180
        expect_acc(2, 1'b0, 12'h180, 8'h6A, 1'b1);
        cpu_addr = 12'h180; cpu_req = 1'b1;
        wait_grants(1); step(); cpu_req = 1'b0;
        repeat (4) step();

        // All three request: loader write first, then BLT (pointer moved off CPU), then CPU
        expect_acc(1, 1'b1, 12'h200, 8'h55, 1'b0);
        expect_acc(3, 1'b0, 12'h020, 8'h22, 1'b1);
        expect_acc(2, 1'b0, 12'h010, 8'h11, 1'b1);
        ld_wr = 1'b1; ld_addr = 12'h200; ld_wdata = 8'h55; ld_req = 1'b1;
        cpu_addr = 12'h010; cpu_req = 1'b1;
        blt_addr = 12'h020; blt_req = 1'b1;
        wait_grants(1); step(); ld_req = 1'b0;
        wait_grants(1); step(); blt_req = 1'b0;
        wait_grants(1); step(); cpu_req = 1'b0;
        repeat (3) step();
        // Read back the loader's write
        expect_acc(2, 1'b0, 12'h200, 8'h55, 1'b1);
        cpu_addr = 12'h200; cpu_req = 1'b1;
        wait_grants(1); step(); cpu_req = 1'b0;
        repeat (4) step();

        // Fresh reset, then CPU and BLT both held: strict alternation starting with CPU
        res = 1'b1; repeat (2) step(); res = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_acc(2, 1'b0, 12'h010, 8'h11, 1'b1);
            expect_acc(3, 1'b0, 12'h020, 8'h22, 1'b1);
        end
        cpu_addr = 12'h010; cpu_req = 1'b1;
        blt_addr = 12'h020; blt_req = 1'b1;
        wait_grants(6); step(); cpu_req = 1'b0; blt_req = 1'b0;
        repeat (4) step();

        // Locked 4-row BLT burst with CPU waiting; CPU only after the unlocked last row
        for (int i = 0; i < 4; i++) expect_acc(3, 1'b0, 12'h040 + 12'(i), 8'hA0 + 8'(i), 1'b1);
        expect_acc(2, 1'b0, 12'h010, 8'h11, 1'b1);
        blt_addr = 12'h040; blt_lock = 1'b1; blt_req = 1'b1;
        wait_grants(1); step(); blt_addr = 12'h041; cpu_req = 1'b1;
        wait_grants(1); step(); blt_addr = 12'h042;
        wait_grants(1); step(); blt_addr = 12'h043; blt_lock = 1'b0;
        wait_grants(1); step(); blt_req = 1'b0;
        wait_grants(1); step(); cpu_req = 1'b0;
        repeat (4) step();

        // BLT locked forever: exactly 16 grants, forced release to CPU, then alternation
        for (int i = 0; i < 16; i++) expect_acc(3, 1'b0, 12'h040, 8'hA0, 1'b1);
        expect_acc(2, 1'b0, 12'h010, 8'h11, 1'b1);
        expect_acc(3, 1'b0, 12'h040, 8'hA0, 1'b1);
        expect_acc(2, 1'b0, 12'h010, 8'h11, 1'b1);
        expect_acc(3, 1'b0, 12'h040, 8'hA0, 1'b1);
        expect_acc(2, 1'b0, 12'h010, 8'h11, 1'b1);
        blt_addr = 12'h040; blt_lock = 1'b1; blt_req = 1'b1;
        wait_grants(1); step(); cpu_req = 1'b1;
        wait_grants(15);
        wait_grants(1); step(); blt_lock = 1'b0;
        wait_grants(4); step(); cpu_req = 1'b0; blt_req = 1'b0;
        repeat (4) step();

        // Reset the cycle after a CPU read grant: the read must never return
        expect_acc(2, 1'b0, 12'h010, 8'h11, 1'b0);
        cpu_addr = 12'h010; cpu_req = 1'b1;
        wait_grants(1); step();
        res = 1'b1; cpu_req = 1'b0; blt_req = 1'b1;
        step();
        @(negedge clk);
        reset_checks();
        step();
        res = 1'b0; blt_req = 1'b0;
        repeat (6) step();

        chk("exp_gnt_left", exp_gnt.size(), 0);
        chk("exp_ram_left", exp_ram.size(), 0);
        chk("exp_rd_left", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
